cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical memory port between the split I-cache and D-cache miss/writeback interfaces of the pipelined RV32I core.
- Sits between both caches' line-fill ports and main memory, or L2.
- Grants one requester per transaction and holds that grant until memory responds.
- Routes the response only to the owner, so a D-cache miss stalling the whole pipeline is never starved by instruction refills.

Parameters:
ADDR_W, 32, physical line address width
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_pmem_read  in  1  I-cache line fill request (level, held until i_pmem_resp)
i_pmem_address  in  ADDR_W  I-cache line address
i_pmem_rdata  out  LINE_W  line data to I-cache
i_pmem_resp  out  1  I-cache transaction done
d_pmem_read  in  1  D-cache line fill request (level)
d_pmem_write  in  1  D-cache writeback request (level)
d_pmem_address  in  ADDR_W  D-cache line address
d_pmem_wdata  in  LINE_W  D-cache writeback data
d_pmem_rdata  out  LINE_W  line data to D-cache
d_pmem_resp  out  1  D-cache transaction done
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write data
pmem_rdata  in  LINE_W  memory read data
pmem_resp  in  1  memory transaction done (single-cycle pulse)
arb_busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset state:
  - State = IDLE; last_grant = I.
  - Outputs pmem_read, pmem_write, i_pmem_resp, d_pmem_resp and arb_busy = 0.
  - pmem_address and pmem_wdata = 0.
- Requests: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
- FSM states: IDLE, GRANT_I, GRANT_D, RECOVER.
- IDLE:
  - Memory strobes are 0.
  - d_req alone -> GRANT_D. i_req alone -> GRANT_I.
  - Both -> GRANT_D (fixed priority; see Optional Feature). None -> stay.
- Grant latency: a request sampled high in cycle N gives a memory strobe in cycle N+1. Memory outputs are decoded combinationally from the registered state.
- GRANT_I:
  - pmem_read = i_pmem_read; pmem_write = 0; pmem_address = i_pmem_address.
  - i_pmem_resp = pmem_resp.
- GRANT_D:
  - pmem_write = d_pmem_write; pmem_read = d_pmem_read & ~d_pmem_write (write wins if both are asserted, which is illegal).
  - pmem_address = d_pmem_address; pmem_wdata = d_pmem_wdata.
  - d_pmem_resp = pmem_resp.
- Grant exit:
  - On pmem_resp in GRANT_x -> RECOVER; set last_grant = x.
  - RECOVER lasts exactly 1 cycle with strobes 0, so memory sees a deassert between back-to-back transactions. Then -> IDLE arbitration. The minimum turnaround between grants is therefore 2 cycles after resp.
- Routing:
  - pmem_rdata is broadcast to both i_pmem_rdata and d_pmem_rdata.
  - Only the owner's resp is ever asserted. The non-owner's resp stays 0 in every state.
- Abort: if the owner drops its request while in GRANT_x with no pmem_resp -> RECOVER, no resp issued.
- Stray resp: pmem_resp in IDLE or RECOVER is ignored and never routed.
- Reset mid-transaction: forces IDLE immediately (asynchronous); strobes drop in the same cycle.
- No combinational path from pmem_resp to pmem_read/pmem_write.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined: when both i_req and d_req are high in IDLE, grant the requester opposite last_grant. Reset last_grant = I, so D wins the first tie. Single requests are unchanged.
- Undefined: fixed priority, D always wins ties. last_grant is still maintained but unused for arbitration.

Test Plan:
1. Reset, then i_pmem_read=1, addr 0x00000040; memory returns resp after 5 cycles with rdata=0xA5..A5 -> pmem_read high from cycle 1; i_pmem_resp pulses once with rdata 0xA5..A5; d_pmem_resp stays 0; one RECOVER cycle follows.
2. d_pmem_write=1, addr 0x00001000, wdata 0x1234..; resp after 3 cycles -> pmem_write=1, pmem_read=0, correct address/wdata forwarded; d_pmem_resp pulses once.
3. i_req and d_req rise in the same cycle:
   - Default build -> D served first, then I, with exactly 1 RECOVER cycle between.
   - With CACHE_ARB_ROUND_ROBIN_EN, repeat the tie twice -> grant order D, I, D, I.
4. pmem_resp pulsed while IDLE, and the owner drops its request mid-grant -> no resp routed to either cache; FSM reaches IDLE within 2 cycles.
5. rst_n asserted low during GRANT_D with pmem_write high -> pmem_write and arb_busy drop without a clock edge. After release, the first pending request is re-arbitrated normally.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Cache-to-memory port bundle for cache_arbiter: I-cache, D-cache and memory sides.
// slave is the arbiter's view; master is the caches/memory environment view.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              arb_busy;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write,
    input  d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    output arb_busy
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write,
    output d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    input  arb_busy
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one memory port between I-cache and D-cache line-fill/writeback ports.
// Define CACHE_ARB_ROUND_ROBIN_EN to alternate ties; default gives D priority.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } state_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_e;

  state_e state_q, state_d;
  last_e  last_q, last_d;

  logic i_req;
  logic d_req;
  logic tie_to_d;
  logic gnt_i;
  logic gnt_d;

  logic              rd_o;
  logic              wr_o;
  logic [ADDR_W-1:0] addr_o;
  logic [LINE_W-1:0] wdata_o;
  logic              iresp_o;
  logic              dresp_o;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign tie_to_d = (last_q == LAST_I);
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A grant ends on resp or when its owner withdraws; both pass via RECOVER.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || tie_to_d)) begin
          state_d = GRANT_D;
        end else if (i_req) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I: begin
        if (bus.pmem_resp) begin
          state_d = RECOVER;
          last_d  = LAST_I;
        end else if (!i_req) begin
          state_d = RECOVER;
        end
      end
      GRANT_D: begin
        if (bus.pmem_resp) begin
          state_d = RECOVER;
          last_d  = LAST_D;
        end else if (!d_req) begin
          state_d = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_i = (state_q == GRANT_I);
  assign gnt_d = (state_q == GRANT_D);

  // Strobes depend on state and request levels only, never on pmem_resp.
  always_comb begin
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    iresp_o = 1'b0;
    dresp_o = 1'b0;
    unique case (1'b1)
      gnt_i: begin
        rd_o    = bus.i_pmem_read;
        addr_o  = bus.i_pmem_address;
        iresp_o = bus.pmem_resp;
      end
      gnt_d: begin
        wr_o    = bus.d_pmem_write;
        rd_o    = bus.d_pmem_read & ~bus.d_pmem_write;
        addr_o  = bus.d_pmem_address;
        wdata_o = bus.d_pmem_wdata;
        dresp_o = bus.pmem_resp;
      end
      default: ;
    endcase
  end

  assign bus.pmem_read    = rd_o;
  assign bus.pmem_write   = wr_o;
  assign bus.pmem_address = addr_o;
  assign bus.pmem_wdata   = wdata_o;
  assign bus.i_pmem_resp  = iresp_o;
  assign bus.d_pmem_resp  = dresp_o;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
  assign bus.arb_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: transaction-level model plus
// directed scenarios and a randomized cache/memory traffic phase.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk;
  logic rst_n;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // model: who owns memory (0 none, 1 I, 2 D), cooldown flag, last winner
  int    m_own;
  bit    m_cool;
  bit    m_last_d;
  string glog;

  int cnt_i, cnt_d, rec_cyc;
  logic [LW-1:0] cap_i, cap_d;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_own    = 0;
    m_cool   = 0;
    m_last_d = 0;
  endtask

  task automatic model_step();
    bit ir, dr, pick_d;
    ir = bus.i_pmem_read;
    dr = bus.d_pmem_read | bus.d_pmem_write;
    if (!rst_n) begin
      model_reset();
    end else if (m_own != 0) begin
      if (bus.pmem_resp) begin
        m_last_d = (m_own == 2);
        m_own    = 0;
        m_cool   = 1;
      end else if (!((m_own == 1) ? ir : dr)) begin
        m_own  = 0;
        m_cool = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (ir || dr) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      pick_d = dr && (!ir || !m_last_d);
`else
      pick_d = dr;
`endif
      m_own = pick_d ? 2 : 1;
      glog  = {glog, pick_d ? "D" : "I"};
    end
  endtask

  task automatic clr();
    cnt_i = 0; cnt_d = 0; rec_cyc = 0;
    cap_i = '0; cap_d = '0; glog = "";
  endtask

  // compare every DUT output against the model, away from the clock edge
  task automatic settle();
    logic er, ew, eir, edr, eb;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    #1;
    er = 0; ew = 0; eir = 0; edr = 0; ea = '0; ewd = '0;
    eb = (m_own != 0) || m_cool;
    if (m_own == 1) begin
      er  = bus.i_pmem_read;
      ea  = bus.i_pmem_address;
      eir = bus.pmem_resp;
    end else if (m_own == 2) begin
      ew  = bus.d_pmem_write;
      er  = bus.d_pmem_read & ~bus.d_pmem_write;
      ea  = bus.d_pmem_address;
      ewd = bus.d_pmem_wdata;
      edr = bus.pmem_resp;
    end
    chk("pmem_read", LW'(bus.pmem_read), LW'(er));
    chk("pmem_write", LW'(bus.pmem_write), LW'(ew));
    chk("pmem_address", LW'(bus.pmem_address), LW'(ea));
    chk("pmem_wdata", bus.pmem_wdata, ewd);
    chk("i_pmem_resp", LW'(bus.i_pmem_resp), LW'(eir));
    chk("d_pmem_resp", LW'(bus.d_pmem_resp), LW'(edr));
    chk("arb_busy", LW'(bus.arb_busy), LW'(eb));
    chk("i_pmem_rdata", bus.i_pmem_rdata, bus.pmem_rdata);
    chk("d_pmem_rdata", bus.d_pmem_rdata, bus.pmem_rdata);
    cnt_i += int'(bus.i_pmem_resp);
    cnt_d += int'(bus.d_pmem_resp);
    if (bus.i_pmem_resp) cap_i = bus.i_pmem_rdata;
    if (bus.d_pmem_resp) cap_d = bus.d_pmem_rdata;
    if (bus.arb_busy && !bus.pmem_read && !bus.pmem_write) rec_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // memory answers after lat cycles of grant; caches drop on their resp
  int first_strobe, resp_c, next_start;
  task automatic serve(input int lat, input logic [LW-1:0] rd);
    int held, own_b, c;
    bit rn, ps, done;
    held = 0; ps = 0; done = 0;
    first_strobe = -1; resp_c = -1; next_start = -1;
    for (c = 0; c < 200 && !done; c++) begin
      bus.pmem_resp  = (m_own != 0) && (held == lat);
      bus.pmem_rdata = rd;
      rn    = bus.pmem_resp;
      own_b = m_own;
      settle();
      if ((bus.pmem_read || bus.pmem_write) && !ps) begin
        if (first_strobe < 0) first_strobe = c;
        else if (next_start < 0) next_start = c;
      end
      ps = bus.pmem_read || bus.pmem_write;
      if (rn && resp_c < 0) resp_c = c;
      tick();
      if (rn && own_b == 1) bus.i_pmem_read = 0;
      if (rn && own_b == 2) begin
        bus.d_pmem_read  = 0;
        bus.d_pmem_write = 0;
      end
      held = (m_own != 0 && own_b == m_own && !rn) ? held + 1 :
             (m_own != 0) ? 1 : 0;
      done = !bus.i_pmem_read && !bus.d_pmem_read && !bus.d_pmem_write
             && m_own == 0 && !m_cool;
    end
    bus.pmem_resp = 0;
    if (!done) chk("serve_timeout", LW'(1), LW'(0));
  endtask

  logic [LW-1:0] a5, wd;

  initial begin
    n_chk = 0; n_pass = 0;
    model_reset(); clr();
    rst_n = 0;
    bus.i_pmem_read = 0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 0; bus.d_pmem_write = 0;
    bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
    @(negedge clk);
    settle();
    chk("rst_busy", LW'(bus.arb_busy), LW'(0));
    chk("rst_addr", LW'(bus.pmem_address), LW'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // 1: I-cache fill, 5-cycle memory
    a5 = {32{8'hA5}};
    clr();
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_0040;
    serve(5, a5);
    chk("t1_first_strobe", LW'(first_strobe), LW'(1));
    chk("t1_i_resps", LW'(cnt_i), LW'(1));
    chk("t1_d_resps", LW'(cnt_d), LW'(0));
    chk("t1_rdata", cap_i, a5);
    chk("t1_recover", LW'(rec_cyc), LW'(1));
    chk("t1_log", LW'(glog == "I"), LW'(1));

    // 2: D-cache writeback, 3-cycle memory
    clr();
    wd = {8{32'h1234_5678}};
    bus.d_pmem_write = 1; bus.d_pmem_address = 32'h0000_1000;
    bus.d_pmem_wdata = wd;
    settle();
    tick();
    settle();
    chk("t2_write", LW'(bus.pmem_write), LW'(1));
    chk("t2_read", LW'(bus.pmem_read), LW'(0));
    chk("t2_addr", LW'(bus.pmem_address), LW'(32'h0000_1000));
    chk("t2_wdata", bus.pmem_wdata, wd);
    tick();
    serve(2, rnd_line());
    chk("t2_d_resps", LW'(cnt_d), LW'(1));
    chk("t2_i_resps", LW'(cnt_i), LW'(0));

    // 3: simultaneous requests, twice
    clr();
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_2000;
    bus.d_pmem_read = 1; bus.d_pmem_address = 32'h0000_3000;
    serve(2, rnd_line());
    chk("t3_gap", LW'(next_start - resp_c), LW'(3));
    chk("t3_recover", LW'(rec_cyc), LW'(2));
    bus.i_pmem_read = 1; bus.d_pmem_read = 1;
    serve(2, rnd_line());
    chk("t3_log", LW'(glog == "DIDI"), LW'(1));
    chk("t3_resps", LW'(cnt_i * 10 + cnt_d), LW'(22));

    // 3b: tie right after a D grant
    clr();
    bus.d_pmem_read = 1;
    serve(1, rnd_line());
    bus.i_pmem_read = 1; bus.d_pmem_read = 1;
    serve(1, rnd_line());
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    chk("t3b_log", LW'(glog == "DID"), LW'(1));
`else
    chk("t3b_log", LW'(glog == "DDI"), LW'(1));
`endif

    // 4: stray resp in IDLE, abort mid-grant, stray resp in RECOVER
    clr();
    bus.pmem_resp = 1;
    settle();
    tick();
    bus.pmem_resp = 0;
    bus.i_pmem_read = 1;
    settle(); tick();
    settle(); tick();
    bus.i_pmem_read = 0;
    settle(); tick();
    bus.pmem_resp = 1;
    settle();
    chk("t4_rec_busy", LW'(bus.arb_busy), LW'(1));
    tick();
    bus.pmem_resp = 0;
    settle();
    chk("t4_idle", LW'(bus.arb_busy), LW'(0));
    chk("t4_resps", LW'(cnt_i + cnt_d), LW'(0));
    tick();

    // 5: async reset during a D writeback
    clr();
    bus.d_pmem_write = 1; bus.i_pmem_read = 1;
    settle(); tick();
    settle();
    chk("t5_pre_write", LW'(bus.pmem_write), LW'(1));
    #1 rst_n = 0;
    model_reset();
    settle();
    chk("t5_write_drop", LW'(bus.pmem_write), LW'(0));
    chk("t5_busy_drop", LW'(bus.arb_busy), LW'(0));
    tick();
    rst_n = 1;
    glog = "";
    serve(2, rnd_line());
    chk("t5_log", LW'(glog == "DI"), LW'(1));

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int own_b;
      bit rn;
      if (!bus.i_pmem_read && $urandom_range(0, 2) == 0) begin
        bus.i_pmem_read    = 1;
        bus.i_pmem_address = $urandom;
      end
      if (!bus.d_pmem_read && !bus.d_pmem_write &&
          $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.d_pmem_read = 1;
        else bus.d_pmem_write = 1;
        bus.d_pmem_address = $urandom;
        bus.d_pmem_wdata   = rnd_line();
      end
      if ($urandom_range(0, 39) == 0) bus.i_pmem_read = 0;
      if ($urandom_range(0, 39) == 0) begin
        bus.d_pmem_read = 0; bus.d_pmem_write = 0;
      end
      bus.pmem_resp  = ($urandom_range(0, 3) == 0);
      bus.pmem_rdata = rnd_line();
      rn    = bus.pmem_resp;
      own_b = m_own;
      settle();
      tick();
      if (rn && own_b == 1) bus.i_pmem_read = 0;
      if (rn && own_b == 2) begin
        bus.d_pmem_read = 0; bus.d_pmem_write = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
